// File: rtl/secded_encoder_if.sv
// secded_encoder_if: upstream data and downstream codeword valid/ready channels
interface secded_encoder_if;
    logic [7:0]  data_in;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] out_code;
    logic        out_valid;
    logic        out_ready;
    modport master (output data_in, in_valid, out_ready, input in_ready, out_code, out_valid);
    modport slave  (input data_in, in_valid, out_ready, output in_ready, out_code, out_valid);
endinterface

// File: rtl/secded_encoder.sv
// secded_encoder: 8-bit to 13-bit SECDED encoder feeding a codeword FIFO; SECDED_ERR_INJECT_EN enables XOR error injection
module secded_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset_L,
    secded_encoder_if.slave          bus,
    input  logic                     flush,
    input  logic                     inj_en,
    input  logic [12:0]              inj_mask,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         word_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             live_q, live_d;
    logic [12:0]      mem_q [DEPTH];
    logic [12:0]      mem_d [DEPTH];
    logic [7:0]       d;
    logic [12:1]      h;
    logic [12:0]      code, stored;
    logic             full, empty, push, pop;
    assign d    = bus.data_in;
    assign h    = {d[7:4], ^d[7:4], d[3:1], d[1] ^ d[2] ^ d[3] ^ d[7], d[0],
                   d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6], d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6]};
    assign code = {h, ^h};
`ifdef SECDED_ERR_INJECT_EN
    assign stored = code ^ (inj_en ? inj_mask : 13'h0000);
`else
    logic unused_inj;
    assign unused_inj = ^{inj_en, inj_mask};
    assign stored     = code;
`endif
    assign empty         = wr_ptr_q == rd_ptr_q;
    assign full          = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign bus.in_ready  = live_q && !full && !flush;
    assign bus.out_valid = !empty;
    assign bus.out_code  = mem_q[rd_ptr_q[AW-1:0]];
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready && !flush;
    assign occupancy     = wr_ptr_q - rd_ptr_q;
    assign word_count    = word_count_q;
    always_comb begin
        live_d       = 1'b1;
        wr_ptr_d     = flush ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d     = flush ? '0 : rd_ptr_q + PW'(pop);
        word_count_d = word_count_q + CNT_W'(push);
        for (int i = 0; i < DEPTH; i++)
            mem_d[i] = (push && wr_ptr_q[AW-1:0] == AW'(i)) ? stored : mem_q[i];
    end
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            live_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            word_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            live_q       <= live_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            word_count_q <= word_count_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end
endmodule

// File: tb/tb_secded_encoder.sv
// tb_secded_encoder: directed checks of encoding, FIFO flow control, flush, reset and injection
module tb_secded_encoder;
    localparam int DEPTH = 4;
`ifdef SECDED_ERR_INJECT_EN
    localparam logic [12:0] INJ1 = 13'h1ECE;
    localparam logic [12:0] INJ2 = 13'h1EED;
`else
    localparam logic [12:0] INJ1 = 13'h1EEE;
    localparam logic [12:0] INJ2 = 13'h1EEE;
`endif
    logic        clock, reset_L, flush, inj_en;
    logic [12:0] inj_mask;
    logic [2:0]  occupancy;
    logic [15:0] word_count;
    logic [12:0] q[$];
    int          total, bad, wc;
    secded_encoder_if bus();
    secded_encoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clock(clock), .reset_L(reset_L), .bus(bus), .flush(flush), .inj_en(inj_en),
        .inj_mask(inj_mask), .occupancy(occupancy), .word_count(word_count)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [12:0] enc(input logic [7:0] dv);
        logic [12:0] c = '0;
        int k = 0;
        for (int pos = 1; pos <= 12; pos++)
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = dv[k];
                k++;
            end
        for (int p = 1; p <= 8; p = p * 2)
            for (int pos = 1; pos <= 12; pos++)
                if ((pos & p) != 0 && pos != p) c[p] = c[p] ^ c[pos];
        c[0] = ^c[12:1];
        return c;
    endfunction
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic cyc(input logic v, input logic [7:0] dv, input logic r);
        logic popq, pushq;
        bus.in_valid = v;
        bus.data_in = dv;
        bus.out_ready = r;
        #2;
        chk("in_ready", bus.in_ready, q.size() < DEPTH);
        chk("out_valid", bus.out_valid, q.size() != 0);
        popq = r && q.size() != 0;
        pushq = v && q.size() < DEPTH;
        if (popq) begin
            chk("order", bus.out_code, q[0]);
            chk("parity", ^bus.out_code, 0);
        end
        tick();
        if (popq) void'(q.pop_front());
        if (pushq) begin
            q.push_back(enc(dv));
            wc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("occupancy", occupancy, q.size());
        chk("word_count", word_count, wc[15:0]);
    endtask
    initial begin
        total = 0; bad = 0; wc = 0;
        reset_L = 1'b0; flush = 1'b0; inj_en = 1'b0; inj_mask = '0;
        bus.in_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_wc", word_count, 0);
        repeat (2) tick();
        reset_L = 1'b1;
        tick();
        chk("post_rst_ready", bus.in_ready, 1);
        cyc(1, 8'h00, 0);
        chk("code_00", bus.out_code, 13'h0000);
        chk("valid_00", bus.out_valid, 1);
        cyc(0, 8'h00, 1);
        cyc(1, 8'hFF, 1);
        chk("code_ff", bus.out_code, 13'h1EEE);
        cyc(1, 8'h01, 1);
        chk("code_01", bus.out_code, 13'h000F);
        cyc(0, 8'h00, 1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 8'(i * 16), 0);
            if (i == 1) chk("code_10", bus.out_code, 13'h0303);
        end
        chk("full_occ", occupancy, 4);
        chk("full_ready", bus.in_ready, 0);
        cyc(0, 8'h00, 1);
        cyc(1, 8'h60, 0);
        chk("refill_occ", occupancy, 4);
        repeat (4) cyc(0, 8'h00, 1);
        cyc(1, 8'hA5, 0);
        cyc(1, 8'h5A, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 8'(8'h31 + i * 8'h17), 1);
            chk("half_occ", occupancy, 2);
        end
        repeat (2) cyc(0, 8'h00, 1);
        repeat (3) cyc(1, 8'hC3, 0);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #2;
        chk("flush_ready", bus.in_ready, 0);
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        q.delete();
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_occ", occupancy, 0);
        chk("flush_wc", word_count, wc[15:0]);
        cyc(1, 8'h7E, 0);
        cyc(1, 8'h81, 0);
        reset_L = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_wc", word_count, 0);
        chk("arst_ready", bus.in_ready, 0);
        #2;
        reset_L = 1'b1;
        q.delete();
        wc = 0;
        tick();
        chk("rerst_ready", bus.in_ready, 1);
        inj_en = 1'b1;
        inj_mask = 13'h0020;
        bus.data_in = 8'hFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("inj_1bit", bus.out_code, INJ1);
        chk("inj_wc", word_count, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        inj_mask = 13'h0003;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("inj_2bit", bus.out_code, INJ2);
        chk("inj_wc2", word_count, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/secded_encoder.md
Name: secded_encoder

Overview:
- Streaming SECDED encoder: the transmit-side counterpart of the team's 13-bit SECDED decoder.
- Accepts 8-bit data words over a valid/ready handshake, builds the 13-bit Hamming+overall-parity codeword, and buffers codewords in a small FIFO.
- Presents buffered codewords downstream over a second valid/ready handshake.
- Feeds the memory/link path whose far end is the SECDED decoder.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset_L  input  1  asynchronous, active-low reset
- data_in  input  8  data word d[7:0]
- in_valid  input  1  data_in is valid this cycle
- in_ready  output  1  block can accept a word this cycle
- out_code  output  13  codeword at FIFO head
- out_valid  output  1  out_code is valid
- out_ready  input  1  downstream consumes out_code this cycle
- flush  input  1  synchronous clear of FIFO contents
- inj_en  input  1  error-injection enable (see Optional Feature)
- inj_mask  input  13  error-injection XOR mask
- occupancy  output  $clog2(DEPTH)+1  entries currently held
- word_count  output  CNT_W  words accepted since reset

Behaviour:
- Codeword layout, positions 12..1 (Hamming):
  - Data bits: d0..d7 at positions 3, 5, 6, 7, 9, 10, 11, 12 respectively.
  - Parity bits: p1 at bit 1, p2 at bit 2, p4 at bit 4, p8 at bit 8.
  - p1 = XOR of bits 3, 5, 7, 9, 11.
  - p2 = XOR of bits 3, 6, 7, 10, 11.
  - p4 = XOR of bits 5, 6, 7, 12.
  - p8 = XOR of bits 9, 10, 11, 12.
- Bit 0 is the overall parity, chosen so that the XOR of all 13 bits is 0 (even).
- A valid codeword therefore gives decoder syndrome 0 and no parity failure.
- Encoding is combinational on data_in; the FIFO stores finished codewords.
- Push occurs when in_valid && in_ready.
  - in_ready = !full. It does not depend on out_ready, so there is no pass-through when full.
- Pop occurs when out_valid && out_ready.
  - out_valid = !empty.
  - out_code = head entry, driven from registered storage.
- Latency: a word pushed in cycle N gives out_valid=1 in cycle N+1 if the FIFO was empty. There is no same-cycle bypass.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, order preserved.
- Push to an empty FIFO while out_ready=1: the word is still accepted; no pop that cycle because out_valid=0.
- Read/write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. Full/empty come from pointer MSB compare.
- occupancy = wr_ptr - rd_ptr, range 0..DEPTH.
- word_count increments on each push, wraps modulo 2^CNT_W, and is unaffected by flush.
- flush (synchronous):
  - Next cycle: pointers are reset, occupancy=0, out_valid=0.
  - in_ready is forced to 0 during the flush cycle, so no push occurs.
  - A pop in the flush cycle is ignored.
- Reset values (reset_L=0, asynchronous):
  - Pointers 0, occupancy 0, out_valid 0, in_ready 0 while reset is asserted, word_count 0.
  - in_ready returns to 1 in the first cycle after reset deasserts.
  - out_code reads the stored contents of entry 0, which is don't-care while out_valid=0.
- Reset asserted mid-transfer: all in-flight data is discarded immediately; no partial codeword is ever presented.
- Stored data must not change while out_valid=1 and out_ready=0 (hold stable until consumed).

Optional Feature:
- Macro: SECDED_ERR_INJECT_EN.
- Defined: on a push with inj_en=1, the stored codeword is the encoded word XOR inj_mask. This lets the bench drive the decoder with 1-bit and 2-bit errors. word_count counts injected words normally.
- Not defined: inj_en and inj_mask remain as ports but are ignored; the stored codeword is always clean. No extra logic is synthesised.

Test Plan:
- Reset, then push data_in=8'h00 -> the next cycle gives out_valid=1, out_code=13'h0000, occupancy=1, word_count=1.
- Push 8'hFF, then 8'h01, with out_ready=1 -> out_code=13'h1EEE, then 13'h000F, in order; the XOR of every output word is 0.
- Hold out_ready=0 and push 5 words with DEPTH=4 -> in_ready=0 after the 4th push, the 5th is not accepted, occupancy=4. Then one pop/push cycle pair leaves occupancy at 4 and drains in order.
- Half-full FIFO with simultaneous push and pop for 8 cycles -> occupancy constant, output order matches input order across pointer wrap.
- flush with 3 entries queued -> next cycle out_valid=0, occupancy=0, word_count unchanged. Also assert reset_L=0 mid-stream -> outputs clear asynchronously.
- With SECDED_ERR_INJECT_EN defined: push 8'hFF with inj_en=1, inj_mask=13'h0020 -> out_code=13'h1ECE. With inj_mask=13'h0003 -> out_code=13'h1EED. With the macro undefined, the same stimulus gives 13'h1EEE.
